// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register with a
// one-entry hold buffer, and redirect flush. Optional macro: IF_MISALIGN_CHK_EN.
module if_stage #(
    localparam int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] next_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
`ifdef IF_MISALIGN_CHK_EN
    output logic            id_misalign,
`endif
    output logic [XLEN-1:0] id_pc_plus4
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;

    logic req_fire;
    logic id_free;
    logic rsp_direct;
    logic rsp_hold;
    logic hold_drain;

    assign req_fire   = imem_req_valid && imem_req_ready;
    assign id_free    = !id_valid || id_ready;
    assign rsp_direct = (state == S_WAIT) && imem_rsp_valid && id_free && !redirect_valid;
    assign rsp_hold   = (state == S_WAIT) && imem_rsp_valid && !id_free && !redirect_valid;
    assign hold_drain = (state == S_HOLD) && id_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= S_REQ;
        else     state <= state_nxt;
    end

    // Redirect outranks everything except reset; an in-flight fetch is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (req_fire) state_nxt = redirect_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid)      state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                else if (imem_rsp_valid) state_nxt = id_free ? S_REQ : S_HOLD;
            end
            S_HOLD: begin
                if (redirect_valid || id_ready) state_nxt = S_REQ;
            end
            S_DROP: begin
                if (imem_rsp_valid) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // PC register has no enable, so holding means echoing pc_in.
    always_comb begin
        imem_req_valid = 1'b0;
        imem_addr      = pc_in;
        next_pc        = pc_in;
        if (rst) begin
            next_pc = RESET_PC;
        end else begin
            imem_req_valid = (state == S_REQ);
            if (redirect_valid)  next_pc = redirect_target;
            else if (req_fire)   next_pc = pc_in + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_pc       <= '0;
            id_pc_plus4 <= XLEN'(4);
            req_pc      <= '0;
            hold_instr  <= NOP_INSTR;
            hold_pc     <= '0;
        end else begin
            if (req_fire) req_pc <= pc_in;
            if (redirect_valid) begin
                id_valid   <= 1'b0;
                id_instr   <= NOP_INSTR;
                hold_instr <= NOP_INSTR;
                hold_pc    <= '0;
            end else if (rsp_direct) begin
                id_valid    <= 1'b1;
                id_instr    <= imem_rsp_data;
                id_pc       <= req_pc;
                id_pc_plus4 <= req_pc + XLEN'(4);
            end else if (hold_drain) begin
                id_valid    <= 1'b1;
                id_instr    <= hold_instr;
                id_pc       <= hold_pc;
                id_pc_plus4 <= hold_pc + XLEN'(4);
            end else if (id_valid && id_ready) begin
                id_valid <= 1'b0;
            end
            if (rsp_hold) begin
                hold_instr <= imem_rsp_data;
                hold_pc    <= req_pc;
            end
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    logic hold_misalign;

    // Misalignment tag travels with the instruction; decode raises the exception.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_misalign   <= 1'b0;
            hold_misalign <= 1'b0;
        end else begin
            if (redirect_valid) begin
                id_misalign   <= 1'b0;
                hold_misalign <= 1'b0;
            end else if (rsp_direct) begin
                id_misalign <= (req_pc[1:0] != 2'b00);
            end else if (hold_drain) begin
                id_misalign <= hold_misalign;
            end else if (id_valid && id_ready) begin
                id_misalign <= 1'b0;
            end
            if (rsp_hold) hold_misalign <= (req_pc[1:0] != 2'b00);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written redirect/reset
// sequences, and a randomized run against a program-order delivery model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef IF_MISALIGN_CHK_EN
    logic        id_misalign;
`endif

    logic [31:0] pc_reg = 32'hDEAD_0000;

    always #5 clk = ~clk;
    always @(posedge clk) pc_reg <= next_pc;

    if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_reg), .next_pc(next_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc),
`ifdef IF_MISALIGN_CHK_EN
        .id_misalign(id_misalign),
`endif
        .id_pc_plus4(id_pc_plus4)
    );

    int          checks = 0;
    int          errors = 0;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_wait = 0;
    int          fix_lat = 0;
    bit          rand_lat = 1'b0;
    logic [31:0] exp_pc = '0;
    int          delivered = 0;
    bit          prev_stall = 1'b0;
    bit          prev_rst = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;

    typedef struct {
        logic        r;
        logic        idr;
        logic [31:0] exp_nxt;
        logic        exp_rv;
        logic        chk_id;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[12];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then check the cycle-level rules.
    task automatic drive(input logic r, input logic idr, input logic reqr,
                         input logic rd, input logic [31:0] tgt);
        logic [31:0] e;
        rst             = r;
        id_ready        = idr;
        imem_req_ready  = reqr;
        redirect_valid  = rd;
        redirect_target = tgt;
        imem_rsp_valid  = !r && mem_pend && (mem_wait == 0);
        imem_rsp_data   = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
        #1;
        if (r)                            e = RESET_PC;
        else if (rd)                      e = tgt;
        else if (imem_req_valid && reqr)  e = pc_reg + 32'd4;
        else                              e = pc_reg;
        chk("next_pc", next_pc, e);
        chk("imem_addr", imem_addr, pc_reg);
        if (r) chk("req_valid_in_rst", 32'(imem_req_valid), 32'd0);
        if (!r && imem_req_valid && reqr) chk("one_outstanding", 32'(mem_pend), 32'd0);
        if (prev_rst) begin
            chk("post_rst_valid", 32'(id_valid), 32'd0);
            chk("post_rst_instr", id_instr, NOP_INSTR);
        end
        if (prev_stall) begin
            chk("stall_valid", 32'(id_valid), 32'd1);
            chk("stall_pc", id_pc, prev_pc);
            chk("stall_instr", id_instr, prev_instr);
        end
        if (r) begin
            exp_pc = RESET_PC;
        end else if (rd) begin
            exp_pc = tgt;
        end else if (id_valid === 1'b1 && idr) begin
            chk("dlv_pc", id_pc, exp_pc);
            chk("dlv_instr", id_instr, mem_word(exp_pc));
            chk("dlv_plus4", id_pc_plus4, exp_pc + 32'd4);
`ifdef IF_MISALIGN_CHK_EN
            chk("dlv_misalign", 32'(id_misalign), 32'(exp_pc[1:0] != 2'b00));
`endif
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
    endtask

    // Advance the memory model across the clock edge.
    task automatic tick();
        prev_stall = !rst && !redirect_valid && (id_valid === 1'b1) && !id_ready;
        prev_pc    = id_pc;
        prev_instr = id_instr;
        prev_rst   = rst;
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (imem_rsp_valid)               mem_pend = 1'b0;
            else if (mem_pend && mem_wait > 0) mem_wait--;
            if (imem_req_valid && imem_req_ready) begin
                mem_pend = 1'b1;
                mem_addr = imem_addr;
                mem_wait = rand_lat ? int'($urandom_range(0, 2)) : fix_lat;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_id(input string name, input logic [31:0] epc);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (id_valid === 1'b1) begin
                got = 1'b1;
                chk({name, "_pc"}, id_pc, epc);
                chk({name, "_instr"}, id_instr, mem_word(epc));
            end
            tick();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: id_valid never rose, expected pc %h", name, epc);
        end
    endtask

    initial begin
        bit          found;
        logic        r, rd, idr, reqr;
        logic [31:0] tgt;

        // r, idr, next_pc, req_valid, check id, id_valid, id_pc
        tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h04, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h04, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h08, 1'b1, 1'b1, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h08, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h08, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 32'h08, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h08, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 1'b1, 1'b1, 32'h4};
        tbl[10] = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h8};

        rst = 1'b1; id_ready = 1'b0; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; redirect_target = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        @(negedge clk);

        // Reset, first fetches, then decode backpressure into the hold buffer.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r, tbl[i].idr, 1'b1, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_next_pc", i), next_pc, tbl[i].exp_nxt);
            chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].exp_rv));
            if (tbl[i].chk_id) begin
                chk($sformatf("tbl%0d_id_valid", i), 32'(id_valid), 32'(tbl[i].exp_iv));
                if (tbl[i].exp_iv) begin
                    chk($sformatf("tbl%0d_id_pc", i), id_pc, tbl[i].exp_pc);
                    chk($sformatf("tbl%0d_id_instr", i), id_instr, mem_word(tbl[i].exp_pc));
                end
            end
            tick();
        end

        // imem_req_ready low for three cycles at pc 0x10.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("stall_req_addr", imem_addr, 32'h10);
            chk("stall_req_next_pc", next_pc, 32'h10);
            chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_release_next_pc", next_pc, 32'h14);
        tick();

        // Redirect while waiting on the response for 0x20.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (imem_req_valid && imem_addr == 32'h20) begin
                found   = 1'b1;
                fix_lat = 2;
            end
            tick();
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL seek_0x20: request for 0x20 never issued, pc %h", pc_reg);
        end
        fix_lat = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h1000);
        chk("wait_redir_next_pc", next_pc, 32'h1000);
        chk("wait_redir_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("drop_id_valid", 32'(id_valid), 32'd0);
            chk("drop_req_valid", 32'(imem_req_valid), 32'd0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("after_drop_addr", imem_addr, 32'h1000);
        chk("after_drop_req_valid", 32'(imem_req_valid), 32'd1);
        tick();
        wait_id("wait_redir_first", 32'h1000);

        // Redirect coincident with a request handshake at 0x30.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h30);
        tick();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            found = imem_req_valid;
            tick();
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL seek_0x30: no request issued, pc %h", pc_reg);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h2000);
        chk("hs_redir_addr", imem_addr, 32'h30);
        chk("hs_redir_next_pc", next_pc, 32'h2000);
        tick();
        wait_id("hs_redir_first", 32'h2000);

        // PC wrap at the top of the address space.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        wait_id("wrap_first", 32'hFFFF_FFFC);
        wait_id("wrap_second", 32'h0000_0000);

        // Reset while a response sits in the hold buffer.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("hold_rst_next_pc", next_pc, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("hold_rst_plus4", id_pc_plus4, 32'h4);
        chk("hold_rst_addr", imem_addr, 32'h0);
        chk("hold_rst_restart_next_pc", next_pc, 32'h4);
        tick();
        wait_id("hold_rst_first", 32'h0);

        // Randomized traffic against the program-order model.
        rand_lat = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom_range(0, 499) == 0);
            rd   = ($urandom_range(0, 19) == 0);
            tgt  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_FFFC);
            idr  = ($urandom_range(0, 3) != 0);
            reqr = ($urandom_range(0, 2) != 0);
            drive(r, idr, reqr, rd, tgt);
            tick();
        end
        checks++;
        if (delivered < 100) begin
            errors++;
            $display("FAIL random_progress: delivered %0d instructions, required at least 100", delivered);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage. Sits directly downstream of the program counter register and closes the loop back to it.
- Consumes pc_out, issues one instruction-memory request at a time, and captures the returned word into the IF/ID register with a valid/ready handshake to decode.
- Computes next_pc for the PC register, which has no enable: holding means driving next_pc = pc_in.
- Handles decode backpressure and branch/jump redirects with flush.

Parameters:
RESET_PC, 32'h00000000, value driven on next_pc while rst is high; matches the PC reset value.
NOP_INSTR, 32'h00000000, value loaded into id_instr on reset or flush.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
pc_in  input  32  current PC, from pc_out.
next_pc  output  32  combinational next-PC value, to the PC register's next_pc input.
redirect_valid  input  1  branch/jump taken; pulse, 1 cycle.
redirect_target  input  32  target address, valid with redirect_valid.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request.
imem_addr  output  32  fetch address, always pc_in.
imem_rsp_valid  input  1  read data valid; cannot be backpressured.
imem_rsp_data  input  32  instruction word.
id_valid  output  1  IF/ID register holds a valid instruction.
id_ready  input  1  decode accepts the instruction.
id_instr  output  32  fetched instruction.
id_pc  output  32  address of id_instr.
id_pc_plus4  output  32  id_pc + 4, for link/branch computation.

Behaviour:
- Reset (rst=1 at posedge):
  - state=S_REQ; id_valid=0; id_instr=NOP_INSTR; id_pc=0; id_pc_plus4=4; hold buffer empty; drop flag=0.
  - While rst=1: next_pc=RESET_PC and imem_req_valid=0.
- Reset mid-operation: any outstanding request is abandoned. Instruction memory shares the same rst, so no stale response arrives after reset.
- One outstanding request maximum.
- States:
  - S_REQ: imem_req_valid=1, imem_addr=pc_in.
    - On req_valid&&req_ready: capture req_pc=pc_in, next_pc=pc_in+4 (PC advances at request handshake), go to S_WAIT.
    - Otherwise next_pc=pc_in.
  - S_WAIT: imem_req_valid=0, next_pc=pc_in. On imem_rsp_valid:
    - If the IF/ID register is free (!id_valid || id_ready): load id_instr=rsp_data, id_pc=req_pc, id_pc_plus4=req_pc+4, id_valid=1; go to S_REQ.
    - Else: load the hold buffer; go to S_HOLD.
  - S_HOLD: imem_req_valid=0, next_pc=pc_in. When id_ready: IF/ID <= hold buffer, id_valid stays 1; go to S_REQ.
  - S_DROP: imem_req_valid=0, next_pc=pc_in. On imem_rsp_valid: discard the data; go to S_REQ.
- Decode handshake:
  - id_valid&&id_ready with no new load in the same cycle: id_valid <= 0.
  - id_instr, id_pc and id_pc_plus4 are stable while id_valid&&!id_ready.
- Throughput: best case 1 instruction per 2 cycles with zero-wait memory (request cycle plus response cycle).
- Redirect (redirect_valid=1) has highest priority, below rst:
  - next_pc=redirect_target, overriding the +4 advance even if a request handshake occurs in the same cycle.
  - id_valid <= 0, id_instr <= NOP_INSTR, hold buffer cleared.
  - From S_WAIT, or on a request handshake in the same cycle: go to S_DROP.
  - From S_WAIT with imem_rsp_valid in the same cycle: discard the response; go to S_REQ.
  - From S_REQ without handshake, S_HOLD or S_DROP: go to S_REQ, except that S_DROP stays in S_DROP until its response arrives.
- Simultaneous id_ready and response in S_WAIT: load directly into IF/ID; the hold buffer is not used.
- Arithmetic: all +4 operations are 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0 with no flag.
- Low two bits of addresses are passed unmodified.

Optional Feature:
- Macro: IF_MISALIGN_CHK_EN.
- Defined:
  - Adds output id_misalign (1 bit), reset 0. It is set with id_valid when req_pc[1:0]!=0 and follows the instruction through the hold buffer.
  - A misaligned PC still issues the fetch; decode raises the address-error exception.
- Undefined: port absent; no check; behaviour otherwise identical.

Test Plan:
- Reset, then release with imem always ready and 1-cycle response, id_ready=1 -> next_pc sequence 0x0, 0x4, 0x8; id_pc 0x0 with id_instr=mem[0], then id_pc 0x4; id_pc_plus4=id_pc+4.
- Hold id_ready=0 for 5 cycles after the first instruction -> id_instr/id_pc stable at 0x0; second response lands in the hold buffer; no third request; next_pc=pc_in=0x8; release -> id_pc 0x4 appears next cycle.
- imem_req_ready low for 3 cycles at pc=0x10 -> imem_addr=0x10 held, next_pc=0x10 throughout; on ready -> next_pc=0x14.
- redirect_valid with target 0x1000 while in S_WAIT for pc 0x20 -> the response for 0x20 is dropped; id_valid=0; next fetch address 0x1000; first id_pc=0x1000.
- redirect_valid with target 0x2000 coincident with a request handshake at pc 0x30 -> next_pc=0x2000, not 0x34; that response is dropped; id_pc=0x2000 next.
- rst asserted in S_HOLD -> next edge: id_valid=0, id_instr=0x00000000, next_pc=0x0; fetch restarts at 0x0.
